// File: rtl/trivium_pkg.sv
// Shared Trivium constants, FSM state type and key/IV byte-order helper.
package trivium_pkg;

   localparam int unsigned STATE_LEN = 288;
   localparam int unsigned KEY_LEN   = 80;
   localparam int unsigned IV_LEN    = 80;

   // Tap indices into S[287:0]
   localparam int unsigned T1_A   = 65;
   localparam int unsigned T1_B   = 92;
   localparam int unsigned T1_AN0 = 90;
   localparam int unsigned T1_AN1 = 91;
   localparam int unsigned T1_X   = 170;
   localparam int unsigned T2_A   = 161;
   localparam int unsigned T2_B   = 176;
   localparam int unsigned T2_AN0 = 174;
   localparam int unsigned T2_AN1 = 175;
   localparam int unsigned T2_X   = 263;
   localparam int unsigned T3_A   = 242;
   localparam int unsigned T3_B   = 287;
   localparam int unsigned T3_AN0 = 285;
   localparam int unsigned T3_AN1 = 286;
   localparam int unsigned T3_X   = 68;

   typedef enum logic [1:0] {IDLE, INIT, STREAM} state_e;

   // Host byte 0 lands in the most-significant byte.
   function automatic logic [79:0] byte_rev80(input logic [79:0] v);
      logic [79:0] r;
      for (int i = 0; i < 10; i++) begin
         r[8*i +: 8] = v[8*(9-i) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/trivium_step.sv
// One combinational Trivium cipher step: next state and keystream bit.
module trivium_step
   import trivium_pkg::*;
(
   input  logic [STATE_LEN-1:0] i_s,
   output logic [STATE_LEN-1:0] o_s,
   output logic                 o_z
);

   logic w_t1, w_t2, w_t3;
   logic w_n1, w_n2, w_n3;

   assign w_t1 = i_s[T1_A] ^ i_s[T1_B];
   assign w_t2 = i_s[T2_A] ^ i_s[T2_B];
   assign w_t3 = i_s[T3_A] ^ i_s[T3_B];
   assign o_z  = w_t1 ^ w_t2 ^ w_t3;

   assign w_n1 = w_t1 ^ (i_s[T1_AN0] & i_s[T1_AN1]) ^ i_s[T1_X];
   assign w_n2 = w_t2 ^ (i_s[T2_AN0] & i_s[T2_AN1]) ^ i_s[T2_X];
   assign w_n3 = w_t3 ^ (i_s[T3_AN0] & i_s[T3_AN1]) ^ i_s[T3_X];

   // Three shift registers; each drops its top bit and takes feedback at its base.
   assign o_s = {i_s[T3_B-1:T2_B+1], w_n2, i_s[T2_B-1:T1_B+1], w_n1, i_s[T1_B-1:0], w_n3};

endmodule

// File: rtl/trivium_stream_w.sv
// W-bit-per-clock Trivium keystream generator with stored key and valid/ack output.
// Optional TRIVIUM_XOR_EN adds Pin and emits keystream XOR Pin.
module trivium_stream_w
   import trivium_pkg::*;
#(
   parameter int unsigned W           = 1,
   parameter int unsigned INIT_ROUNDS = 1152,
   parameter int unsigned KS_LEN      = 128
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic               EN,
   input  logic [KEY_LEN-1:0] Kin,
   input  logic               Krdy,
   input  logic [IV_LEN-1:0]  Din,
   input  logic               Drdy,
   output logic [W-1:0]       Dout,
   output logic               Dvld,
   input  logic               Dack,
   output logic               BSY,
   output logic               Kvld
`ifdef TRIVIUM_XOR_EN
   ,
   input  logic [W-1:0]       Pin
`endif
);

   localparam int unsigned NINIT  = INIT_ROUNDS / W;
   localparam int unsigned NWORDS = KS_LEN / W;
   localparam int unsigned ICW    = $clog2(NINIT + 1);
   localparam int unsigned WCW    = $clog2(NWORDS + 1);
   localparam logic [ICW-1:0] INIT_LAST = ICW'(NINIT - 1);
   localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORDS);

   state_e               r_state, w_state_nxt;
   logic [STATE_LEN-1:0] r_s, w_s_nxt;
   logic [KEY_LEN-1:0]   r_key, w_key_nxt, w_load_key;
   logic                 r_key_loaded, w_key_loaded_nxt;
   logic                 r_kvld, w_kvld_nxt;
   logic                 r_dvld, w_dvld_nxt;
   logic [W-1:0]         r_dout, w_dout_nxt;
   logic [ICW-1:0]       r_icnt, w_icnt_nxt;
   logic [WCW-1:0]       r_wcnt, w_wcnt_nxt;

   logic [STATE_LEN-1:0] w_chain [W+1];
   logic [W-1:0]         w_z;
   logic [W-1:0]         w_word;

   assign w_chain[0] = r_s;

   for (genvar g = 0; g < W; g++) begin : gen_step
      trivium_step u_step (
         .i_s (w_chain[g]),
         .o_s (w_chain[g+1]),
         .o_z (w_z[g])
      );
   end

`ifdef TRIVIUM_XOR_EN
   assign w_word = w_z ^ Pin;
`else
   assign w_word = w_z;
`endif

   always_comb begin
      w_state_nxt      = r_state;
      w_s_nxt          = r_s;
      w_key_nxt        = r_key;
      w_key_loaded_nxt = r_key_loaded;
      w_kvld_nxt       = 1'b0;
      w_dvld_nxt       = r_dvld;
      w_dout_nxt       = r_dout;
      w_icnt_nxt       = r_icnt;
      w_wcnt_nxt       = r_wcnt;
      w_load_key       = Krdy ? byte_rev80(Kin) : r_key;

      unique case (r_state)
         IDLE: begin
            if (Krdy) begin
               w_key_nxt        = byte_rev80(Kin);
               w_key_loaded_nxt = 1'b1;
               w_kvld_nxt       = 1'b1;
            end
            if (Drdy && (Krdy || r_key_loaded)) begin
               w_s_nxt     = {3'b111, 112'b0, byte_rev80(Din), 13'b0, w_load_key};
               w_icnt_nxt  = '0;
               w_wcnt_nxt  = '0;
               w_state_nxt = INIT;
            end
         end
         INIT: begin
            w_s_nxt    = w_chain[W];
            w_icnt_nxt = r_icnt + ICW'(1);
            if (r_icnt == INIT_LAST) begin
               w_state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (!r_dvld || Dack) begin
               // Counter only reaches NWORDS with a word pending, so this is the final handshake.
               if (r_wcnt == WORD_LAST) begin
                  w_dvld_nxt  = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_s_nxt    = w_chain[W];
                  w_dout_nxt = w_word;
                  w_dvld_nxt = 1'b1;
                  w_wcnt_nxt = r_wcnt + WCW'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_state      <= IDLE;
         r_s          <= '0;
         r_key        <= '0;
         r_key_loaded <= 1'b0;
         r_kvld       <= 1'b0;
         r_dvld       <= 1'b0;
         r_dout       <= '0;
         r_icnt       <= '0;
         r_wcnt       <= '0;
      end else if (EN) begin
         r_state      <= w_state_nxt;
         r_s          <= w_s_nxt;
         r_key        <= w_key_nxt;
         r_key_loaded <= w_key_loaded_nxt;
         r_kvld       <= w_kvld_nxt;
         r_dvld       <= w_dvld_nxt;
         r_dout       <= w_dout_nxt;
         r_icnt       <= w_icnt_nxt;
         r_wcnt       <= w_wcnt_nxt;
      end
   end

   assign Dout = r_dout;
   assign Dvld = r_dvld;
   assign BSY  = (r_state != IDLE);
   assign Kvld = r_kvld;

endmodule
